// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: sequences RS/RW/DATA words onto the 16x2 LCD pins with a timed
// E strobe, runs the power-on init sequence and adds settle time after clear/home.
module lcd_bus_driver #(
  parameter int unsigned PWR_WAIT   = 20,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned E_HIGH_CYC = 1,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned CLR_WAIT   = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IN_VALID,
  input  logic       IN_RS,
  input  logic       IN_RW,
  input  logic [7:0] IN_DATA,
  output logic       IN_READY,
  output logic       INIT_DONE,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MaxCyc =
      max2(max2(max2(PWR_WAIT, SETUP_CYC), max2(E_HIGH_CYC, HOLD_CYC)), CLR_WAIT);
  localparam int CntW = (MaxCyc > 1) ? $clog2(MaxCyc + 1) : 1;

  typedef enum logic [2:0] {
    StPwr,
    StInitLoad,
    StSetup,
    StStrobe,
    StHold,
    StWaitClr,
    StIdle
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;

  logic              e_q, e_d;
  logic              ready_q, ready_d;
  logic              init_done_q, init_done_d;
  logic              rs_q, rs_d;
  logic              rw_q, rw_d;
  logic [7:0]        data_q, data_d;

  logic              pwr_end, setup_end, strobe_end, hold_end, clr_end;
  logic              is_clr, init_more;

  function automatic logic [7:0] init_word(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  assign pwr_end    = (cnt_q == CntW'(PWR_WAIT - 1));
  assign setup_end  = (cnt_q == CntW'(SETUP_CYC - 1));
  assign strobe_end = (cnt_q == CntW'(E_HIGH_CYC - 1));
  assign hold_end   = (cnt_q == CntW'(HOLD_CYC - 1));
  assign clr_end    = (cnt_q == CntW'(CLR_WAIT - 1));

  // Clear and home commands need extra settle time inside the controller.
  assign is_clr    = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));
  assign init_more = !init_done_q && (idx_q != 2'd3);

  // State, counter and init index register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StPwr;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic; counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      StPwr: begin
        if (pwr_end) begin
          state_d = StInitLoad;
          idx_d   = 2'd0;
        end
      end
      StInitLoad: state_d = StSetup;
      StSetup:    if (setup_end) state_d = StStrobe;
      StStrobe:   if (strobe_end) state_d = StHold;
      StHold: begin
        if (hold_end) begin
          if (is_clr && (CLR_WAIT != 0)) begin
            state_d = StWaitClr;
          end else if (init_more) begin
            state_d = StInitLoad;
            idx_d   = idx_q + 2'd1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StWaitClr: begin
        if (clr_end) begin
          if (init_more) begin
            state_d = StInitLoad;
            idx_d   = idx_q + 2'd1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StIdle:  if (IN_VALID && !IN_RW) state_d = StSetup;
      default: state_d = StPwr;
    endcase
    cnt_d = ((state_d != state_q) || (state_q == StIdle)) ? '0 : cnt_q + CntW'(1);
  end

  // Output next values; pins are registered so E is glitch-free and the bus only
  // moves at a load edge (leaving INIT_LOAD or accepting a write in IDLE).
  always_comb begin
    e_d         = (state_d == StStrobe);
    ready_d     = (state_d == StIdle);
    init_done_d = init_done_q | (state_d == StIdle);
    rs_d        = rs_q;
    rw_d        = rw_q;
    data_d      = data_q;
    if (state_q == StInitLoad) begin
      rs_d   = 1'b0;
      rw_d   = 1'b0;
      data_d = init_word(idx_q);
    end else if ((state_q == StIdle) && IN_VALID && !IN_RW) begin
      rs_d   = IN_RS;
      rw_d   = 1'b0;
      data_d = IN_DATA;
    end
  end

  // Output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      e_q         <= 1'b0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      rs_q        <= 1'b0;
      rw_q        <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      e_q         <= e_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
      rs_q        <= rs_d;
      rw_q        <= rw_d;
      data_q      <= data_d;
    end
  end

  assign LCD_E     = e_q;
  assign IN_READY  = ready_q;
  assign INIT_DONE = init_done_q;
  assign LCD_RS    = rs_q;
  assign LCD_RW    = rw_q;
  assign LCD_DATA  = data_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Testbench for lcd_bus_driver: directed steps plus randomized words, checked against
// a timing model derived from the setup/strobe/hold/wait cycle counts.
module tb_lcd_bus_driver;

  localparam int PW = 20;
  localparam int S  = 1;
  localparam int EH = 1;
  localparam int H  = 1;
  localparam int W  = 2;
  localparam int P  = 1 + S + EH + H;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       IN_RS = 1'b0;
  logic       IN_RW = 1'b0;
  logic [7:0] IN_DATA = 8'h00;
  logic       IN_READY, INIT_DONE, LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA;

  lcd_bus_driver #(
    .PWR_WAIT  (PW),
    .SETUP_CYC (S),
    .E_HIGH_CYC(EH),
    .HOLD_CYC  (H),
    .CLR_WAIT  (W)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .IN_VALID (IN_VALID),
    .IN_RS    (IN_RS),
    .IN_RW    (IN_RW),
    .IN_DATA  (IN_DATA),
    .IN_READY (IN_READY),
    .INIT_DONE(INIT_DONE),
    .LCD_E    (LCD_E),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_DATA (LCD_DATA)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Words as {rs, rw, data}: expected strobes vs strobes seen on the pins.
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  logic [9:0] cur_word;
  logic       e_prev = 1'b0;
  logic [7:0] last_data;
  logic       last_rs;
  logic [7:0] init_words[4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample #1 after the edge and log every E pulse.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (LCD_E === 1'b1) begin
      if (e_prev !== 1'b1) begin
        cur_word = {LCD_RS, LCD_RW, LCD_DATA};
        obs_q.push_back(cur_word);
      end else begin
        chk("e_steady", 32'({LCD_RS, LCD_RW, LCD_DATA}), 32'(cur_word));
      end
    end
    e_prev = LCD_E;
  endtask

  task automatic junk_inputs();
    IN_VALID = 1'($urandom_range(0, 1));
    IN_RS    = 1'($urandom_range(0, 1));
    IN_RW    = 1'($urandom_range(0, 1));
    IN_DATA  = 8'($urandom);
  endtask

  // Reset for one edge, then check the whole init sequence tick by tick.
  task automatic do_reset(input bit with_word);
    int fin;
    int t;
    int i;
    int ph;
    logic exp_e;
    logic [7:0] exp_d;
    RESET = 1'b1;
    if (with_word) begin
      IN_VALID = 1'b1;
      IN_RW    = 1'b0;
      IN_RS    = 1'b1;
      IN_DATA  = 8'h41;
    end else begin
      IN_VALID = 1'b0;
    end
    tick();
    RESET    = 1'b0;
    IN_VALID = 1'b0;
    chk("rst_e", 32'(LCD_E), 32'd0);
    chk("rst_rs", 32'(LCD_RS), 32'd0);
    chk("rst_rw", 32'(LCD_RW), 32'd0);
    chk("rst_data", 32'(LCD_DATA), 32'd0);
    chk("rst_ready", 32'(IN_READY), 32'd0);
    chk("rst_done", 32'(INIT_DONE), 32'd0);
    for (int n = 0; n < 4; n++) exp_q.push_back({2'b00, init_words[n]});
    fin = PW + 4 * P + W;
    for (int k = 1; k <= fin; k++) begin
      junk_inputs();
      tick();
      t     = k - PW;
      exp_e = 1'b0;
      if (t < 0) begin
        exp_d = 8'h00;
      end else if (t < 4 * P) begin
        i     = t / P;
        ph    = t % P;
        exp_e = (ph > S) && (ph <= S + EH);
        if (ph == 0) exp_d = (i == 0) ? 8'h00 : init_words[i-1];
        else exp_d = init_words[i];
      end else begin
        exp_d = 8'h01;
      end
      chk("init_e", 32'(LCD_E), 32'(exp_e));
      chk("init_data", 32'(LCD_DATA), 32'(exp_d));
      chk("init_rsrw", 32'({LCD_RS, LCD_RW}), 32'd0);
      chk("init_ready", 32'(IN_READY), 32'(k == fin));
      chk("init_done", 32'(INIT_DONE), 32'(k == fin));
    end
    IN_VALID  = 1'b0;
    last_data = 8'h01;
    last_rs   = 1'b0;
  endtask

  // Present a write word while ready, then check the transfer cycle by cycle.
  task automatic xfer(input logic rs, input logic [7:0] data, input bit junk,
                      input bit hold_next);
    int fin;
    bit clr;
    chk("ready_pre", 32'(IN_READY), 32'd1);
    IN_VALID = 1'b1;
    IN_RW    = 1'b0;
    IN_RS    = rs;
    IN_DATA  = data;
    tick();
    exp_q.push_back({rs, 1'b0, data});
    clr = !rs && (data >= 8'h01) && (data <= 8'h03);
    fin = S + EH + H + (clr ? W : 0);
    for (int k = 0; k <= fin; k++) begin
      chk("xfer_e", 32'(LCD_E), 32'((k >= S) && (k < S + EH)));
      chk("xfer_ready", 32'(IN_READY), 32'(k == fin));
      chk("xfer_data", 32'(LCD_DATA), 32'(data));
      chk("xfer_rs", 32'(LCD_RS), 32'(rs));
      chk("xfer_rw", 32'(LCD_RW), 32'd0);
      chk("xfer_done", 32'(INIT_DONE), 32'd1);
      if (k < fin) begin
        if (junk) junk_inputs();
        tick();
      end else if (!hold_next) begin
        IN_VALID = 1'b0;
      end
    end
    last_data = data;
    last_rs   = rs;
  endtask

  // Read/idle marker: consumed in IDLE, no strobe, bus untouched.
  task automatic rw_marker(input int n, input logic [7:0] data);
    IN_VALID = 1'b1;
    IN_RW    = 1'b1;
    IN_RS    = 1'b1;
    IN_DATA  = data;
    repeat (n) begin
      tick();
      chk("rw_e", 32'(LCD_E), 32'd0);
      chk("rw_ready", 32'(IN_READY), 32'd1);
      chk("rw_data", 32'(LCD_DATA), 32'(last_data));
      chk("rw_rs", 32'(LCD_RS), 32'(last_rs));
    end
    IN_VALID = 1'b0;
    IN_RW    = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    IN_VALID = 1'b0;
    repeat (n) begin
      tick();
      chk("idle_e", 32'(LCD_E), 32'd0);
      chk("idle_ready", 32'(IN_READY), 32'd1);
    end
  endtask

  initial begin
    logic       rs;
    logic [7:0] data;

    // Power-on init.
    do_reset(1'b0);

    // Character write, then clear command, then a read marker.
    xfer(1'b1, 8'h54, 1'b0, 1'b0);
    idle_gap(1);
    xfer(1'b0, 8'h01, 1'b0, 1'b0);
    rw_marker(3, 8'h02);

    // Back-to-back stream with VALID held high.
    xfer(1'b0, 8'h80, 1'b0, 1'b1);
    for (int n = 0; n < 16; n++) xfer(1'b1, 8'h20, 1'b0, n < 15);
    idle_gap(2);

    // Randomized words, clear/home biased, with junk on the inputs while busy.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        rw_marker(int'($urandom_range(1, 3)), 8'($urandom));
      end else begin
        rs   = 1'($urandom_range(0, 1));
        data = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
        xfer(rs, data, 1'b1, 1'b0);
      end
      idle_gap(int'($urandom_range(0, 2)));
    end

    // Reset while E is high: init must restart from scratch.
    chk("ready_pre_mid", 32'(IN_READY), 32'd1);
    IN_VALID = 1'b1;
    IN_RW    = 1'b0;
    IN_RS    = 1'b1;
    IN_DATA  = 8'h5A;
    tick();
    exp_q.push_back({1'b1, 1'b0, 8'h5A});
    IN_VALID = 1'b0;
    repeat (S) tick();
    chk("mid_e_high", 32'(LCD_E), 32'd1);
    do_reset(1'b0);

    // Reset and a valid word on the same edge: the word is dropped.
    do_reset(1'b1);
    xfer(1'b1, 8'h33, 1'b0, 1'b0);

    // Every strobe seen on the pins, in order, against the expected word list.
    chk("pulse_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int n = 0; n < obs_q.size() && n < exp_q.size(); n++) begin
      chk("pulse_word", 32'(obs_q[n]), 32'(exp_q[n]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
